m00_axis_src_arbiter: RTL and testbench
=======================================

# m00_axis_src_arbiter

Packet-level round-robin arbiter that shares the single output-stream FIFO write port among `NUM_SRC` CNN result producers (e.g. per-channel or per-layer output engines). It sits directly upstream of the output AXI-Stream FIFO. It grants one source at a time, holds the grant until that source's `last` beat, and forwards data/last/user into the FIFO write port under FIFO back-pressure. It also enforces a maximum packet length and reports status.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesting sources (2..8)
- `DATA_WIDTH`, 32, beat width; must match the output FIFO data width
- `MAX_BEATS`, 1024, maximum beats per packet before forced truncation (≥2)

Ports:
- `M_AXIS_ACLK`  in  1  sole clock, rising edge
- `M_AXIS_ARESET`  in  1  asynchronous, active-high reset
- `src_valid`  in  NUM_SRC  per-source beat valid
- `src_ready`  out  NUM_SRC  per-source beat accept
- `src_data`  in  NUM_SRC*DATA_WIDTH  source s occupies bits [s*DATA_WIDTH +: DATA_WIDTH]
- `src_last`  in  NUM_SRC  end-of-packet marker
- `src_user`  in  NUM_SRC  start-of-frame marker, passed through
- `src_enable`  in  NUM_SRC  arbitration mask; 0 excludes the source from new grants
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_full`  in  1  FIFO full flag
- `fifo_data`  out  DATA_WIDTH  FIFO write data
- `fifo_last`  out  1  FIFO last bit
- `fifo_user`  out  1  FIFO user bit
- `busy`  out  1  high while in XFER
- `grant_id`  out  $clog2(NUM_SRC)  currently or last granted source
- `pkt_done`  out  1  one-cycle pulse on the final beat of each packet
- `trunc_err`  out  1  sticky; set when a packet is force-terminated
- `trunc_clr`  in  1  synchronous clear for `trunc_err`

## Operation
- FSM states: IDLE, XFER.
- **IDLE:** `src_ready`=0 and `fifo_wr_en`=0.
  - Request vector = `src_valid & src_enable`.
  - If the vector is nonzero, select the first set bit, searching from `rr_ptr+1` with wrap modulo NUM_SRC.
  - Register that index into `grant_id`, clear `beat_cnt`, go to XFER.
- **XFER:** with g = `grant_id`:
  - `src_ready[g]` = !`fifo_full`; all other `src_ready` bits = 0.
  - beat = `src_valid[g]` && !`fifo_full`.
  - `fifo_wr_en` = beat. `fifo_data`/`fifo_user` = source g's data/user, combinational mux.
  - `fifo_last` = `src_last[g]` OR (`beat_cnt` == MAX_BEATS-1).
- **On each beat:** `beat_cnt` += 1.
- **On a beat with `fifo_last`=1:**
  - pulse `pkt_done`, set `rr_ptr` to g, go to IDLE.
  - If `src_last[g]`=0 (forced termination), set `trunc_err`. The source's remaining beats are treated as a new packet on its next grant.
- `beat_cnt` is $clog2(MAX_BEATS+1) bits wide and never exceeds MAX_BEATS-1.
- `src_enable` changes affect only the next arbitration, never a packet already in progress.
- `trunc_clr` and a truncation in the same cycle: set wins.
- `src_valid[g]` low mid-packet: XFER is held indefinitely, with no timeout.

## Timing
- **Reset values:**
  - `busy`=0, `grant_id`=0, `pkt_done`=0, `trunc_err`=0
  - `src_ready`=0, `fifo_wr_en`=0
  - `rr_ptr`=NUM_SRC-1, so source 0 wins the first arbitration
  - `beat_cnt`=0
- Reset asserted mid-packet returns the block to IDLE immediately. The partial packet already in the FIFO is not repaired.
- **Arbitration latency:** a request seen in IDLE at cycle n gives the earliest first beat at cycle n+1.
- There is one IDLE bubble cycle between consecutive packets.
- **Throughput:** 1 beat/cycle in XFER while `fifo_full`=0.
- `fifo_full` high blocks the beat combinationally in the same cycle; no data is dropped or duplicated.
- `pkt_done` is registered and high in the cycle after the final beat.
- `busy` = (state==XFER).
- `src_data`/`src_user` need only be stable while `src_valid`=1 and `src_ready`=0 (standard AXIS rule).

## Structure
- Shared package contains:
  - the state enum (IDLE, XFER)
  - localparam `GRANT_W` = $clog2(NUM_SRC) (minimum 1)
  - localparam `CNT_W` = $clog2(MAX_BEATS+1)
- One sub-module, `rr_pick`: combinational rotating-priority selector.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: `found`, `index`.
- The top level holds the FSM, counters and the data mux.

## Test plan
- Reset, then source 0 sends 3 beats (0xA0..0xA2, last on 3rd) -> `fifo_wr_en` high for 3 cycles starting 1 cycle after valid; `fifo_last` only on 0xA2; `pkt_done` one cycle later; `grant_id`=0.
- All 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0,…; one idle cycle between packets; every `fifo_last` matches its source.
- `fifo_full` held high for 5 cycles mid-packet -> no `fifo_wr_en` and `src_ready[g]`=0 during the stall; beat sequence is intact afterwards.
- MAX_BEATS=4, source 2 sends 6 beats without last -> beat 4 has `fifo_last`=1 and `trunc_err` sets; beats 5–6 go out as a later packet; `trunc_clr` then clears `trunc_err`.
- `src_enable`=4'b1011 with sources 1,2,3 valid -> source 2 is never granted. Deassert `src_enable[1]` mid-packet of source 1 -> that packet completes normally.
- Assert `M_AXIS_ARESET` during the 2nd beat of a packet -> all outputs take their reset values asynchronously; after release, source 0 has first priority.

Source files
------------

// File: rtl/m00_axis_src_arbiter_pkg.sv
// Shared types and width helpers for the output-stream source arbiter.
// Widths are exposed as functions so every instance can size itself from its own parameters.
package m00_axis_src_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic int f_grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int f_cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    localparam int NUM_SRC_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int MAX_BEATS_DEF  = 1024;
    localparam int GRANT_W        = f_grant_w(NUM_SRC_DEF);
    localparam int CNT_W          = f_cnt_w(MAX_BEATS_DEF);

endpackage

// File: rtl/m00_axis_src_arbiter_if.sv
// Bundle of source-side, FIFO-write-side and status signals of the arbiter.
// master = the arbiter itself; slave = sources, FIFO and status consumer.
interface m00_axis_src_arbiter_if
    import m00_axis_src_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    localparam int GW = f_grant_w(NUM_SRC);

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_ready;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_last;
    logic [NUM_SRC-1:0]            src_user;
    logic [NUM_SRC-1:0]            src_enable;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_last;
    logic                          fifo_user;
    logic                          busy;
    logic [GW-1:0]                 grant_id;
    logic                          pkt_done;
    logic                          trunc_err;
    logic                          trunc_clr;

    modport master (
        input  src_valid, src_data, src_last, src_user, src_enable, fifo_full, trunc_clr,
        output src_ready, fifo_wr_en, fifo_data, fifo_last, fifo_user,
               busy, grant_id, pkt_done, trunc_err
    );

    modport slave (
        output src_valid, src_data, src_last, src_user, src_enable, fifo_full, trunc_clr,
        input  src_ready, fifo_wr_en, fifo_data, fifo_last, fifo_user,
               busy, grant_id, pkt_done, trunc_err
    );

endinterface

// File: rtl/m00_axis_src_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first set request after i_ptr, wrapping.
// Pure combinational, no state, no backpressure.
module m00_axis_src_arbiter_rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int GW      = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [GW-1:0]      i_ptr,
    output logic               o_found,
    output logic [GW-1:0]      o_index
);
    logic [GW-1:0] w_idx;

    // Walk from the farthest candidate down to ptr+1 so the nearest one wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = GW'((int'(i_ptr) + k) % NUM_SRC);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_index = w_idx;
            end
        end
    end

endmodule

// File: rtl/m00_axis_src_arbiter.sv
// Packet round-robin arbiter feeding the output FIFO write port; grant held until last beat.
// First beat one cycle after request; 1 beat/cycle; fifo_full stalls the granted source same cycle.
module m00_axis_src_arbiter
    import m00_axis_src_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF
) (
    input  logic                    M_AXIS_ACLK,
    input  logic                    M_AXIS_ARESET,
    m00_axis_src_arbiter_if.master  io_arb
);
    localparam int GW = f_grant_w(NUM_SRC);
    localparam int CW = f_cnt_w(MAX_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    state_t                  r_state, w_state_nxt;
    logic [GW-1:0]           r_grant, r_rr_ptr, w_pick_idx;
    logic [CW-1:0]           r_beat_cnt;
    logic                    r_pkt_done, r_trunc_err;
    logic                    w_found, w_beat, w_last, w_src_last;
    logic [NUM_SRC-1:0]      w_req, w_src_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_user;

    assign w_req = io_arb.src_valid & io_arb.src_enable;

    m00_axis_src_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .GW      (GW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_index (w_pick_idx)
    );

    always_comb begin
        w_data = '0;
        w_user = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (GW'(s) == r_grant) begin
                w_data = io_arb.src_data[s*DATA_WIDTH +: DATA_WIDTH];
                w_user = io_arb.src_user[s];
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_ready = '0;
        w_beat      = 1'b0;
        w_src_last  = io_arb.src_last[r_grant];
        w_last      = w_src_last || (r_beat_cnt == CNT_LAST);
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                w_src_ready[r_grant] = !io_arb.fifo_full;
                w_beat               = io_arb.src_valid[r_grant] && !io_arb.fifo_full;
                if (w_beat && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter wraps to zero on the closing beat so it never reaches MAX_BEATS.
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            r_grant     <= '0;
            r_rr_ptr    <= GW'(NUM_SRC - 1);
            r_beat_cnt  <= '0;
            r_pkt_done  <= 1'b0;
            r_trunc_err <= 1'b0;
        end else begin
            r_pkt_done <= w_beat && w_last;
            if (r_state == IDLE && w_found) begin
                r_grant    <= w_pick_idx;
                r_beat_cnt <= '0;
            end
            if (w_beat) begin
                if (w_last) begin
                    r_rr_ptr   <= r_grant;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
            if (w_beat && w_last && !w_src_last) begin
                r_trunc_err <= 1'b1;
            end else if (io_arb.trunc_clr) begin
                r_trunc_err <= 1'b0;
            end
        end
    end

    assign io_arb.src_ready  = w_src_ready;
    assign io_arb.fifo_wr_en = w_beat;
    assign io_arb.fifo_data  = w_data;
    assign io_arb.fifo_user  = w_user;
    assign io_arb.fifo_last  = w_last;
    assign io_arb.busy       = (r_state == XFER);
    assign io_arb.grant_id   = r_grant;
    assign io_arb.pkt_done   = r_pkt_done;
    assign io_arb.trunc_err  = r_trunc_err;

endmodule

// File: tb/tb_m00_axis_src_arbiter.sv
// Directed plus randomized bench for m00_axis_src_arbiter against a packet-level reference model.
module tb_m00_axis_src_arbiter;
    import m00_axis_src_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m00_axis_src_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) dif ();

    m00_axis_src_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .io_arb        (dif)
    );

    beat_t q [N][$];
    int          vld_pct = 100;
    int          full_pct = 0;
    logic        force_full = 1'b0;
    logic        clr_req = 1'b0;
    logic [N-1:0] enable = '1;
    int          checks = 0;
    int          errors = 0;
    int          tot_wr = 0;
    int          obs_pkts[$];

    // Reference state: packet owner, beats sent so far, last winner, status flags.
    logic m_busy, m_done, m_trunc;
    int   m_gid, m_cnt, m_rr;
    logic [N-1:0]  e_ready;
    logic          e_wr, e_last, e_user;
    logic [DW-1:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_trunc = 1'b0;
        m_gid = 0; m_cnt = 0; m_rr = N - 1;
    endtask

    function automatic int pending();
        int p;
        p = m_busy ? 1 : 0;
        for (int s = 0; s < N; s++) p += q[s].size();
        return p;
    endfunction

    task automatic add_pkt(input int s, input int n, input logic [DW-1:0] base, input logic with_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + DW'(i);
            b.l = with_last && (i == n - 1);
            b.u = (i == 0);
            q[s].push_back(b);
        end
    endtask

    task automatic drive();
        logic [N-1:0]    v, l, u;
        logic [N*DW-1:0] d;
        v = '0; l = '0; u = '0; d = '0;
        for (int s = 0; s < N; s++) begin
            if (q[s].size() > 0) begin
                v[s] = ($urandom_range(99) < vld_pct);
                d[s*DW +: DW] = q[s][0].d;
                l[s] = q[s][0].l;
                u[s] = q[s][0].u;
            end
        end
        dif.src_valid  = v;
        dif.src_data   = d;
        dif.src_last   = l;
        dif.src_user   = u;
        dif.src_enable = enable;
        dif.fifo_full  = force_full || ($urandom_range(99) < full_pct);
        dif.trunc_clr  = clr_req;
    endtask

    task automatic check_outputs();
        e_ready = '0; e_wr = 1'b0; e_last = 1'b0; e_user = 1'b0; e_data = '0;
        if (m_busy) begin
            if (!dif.fifo_full) e_ready[m_gid] = 1'b1;
            e_wr   = dif.src_valid[m_gid] && !dif.fifo_full;
            e_last = dif.src_last[m_gid] || (m_cnt == MB - 1);
            if (e_wr) begin
                e_data = q[m_gid][0].d;
                e_user = q[m_gid][0].u;
            end
        end
        chk("src_ready",  64'(dif.src_ready),  64'(e_ready));
        chk("fifo_wr_en", 64'(dif.fifo_wr_en), 64'(e_wr));
        chk("busy",       64'(dif.busy),       64'(m_busy));
        chk("grant_id",   64'(dif.grant_id),   64'(m_gid));
        chk("pkt_done",   64'(dif.pkt_done),   64'(m_done));
        chk("trunc_err",  64'(dif.trunc_err),  64'(m_trunc));
        if (e_wr) begin
            chk("fifo_data", 64'(dif.fifo_data), 64'(e_data));
            chk("fifo_last", 64'(dif.fifo_last), 64'(e_last));
            chk("fifo_user", 64'(dif.fifo_user), 64'(e_user));
        end
        if (dif.fifo_wr_en && dif.fifo_last) obs_pkts.push_back(int'(dif.grant_id));
    endtask

    task automatic advance();
        logic [N-1:0] req;
        logic         found, tset;
        found = 1'b0;
        tset  = 1'b0;
        req   = dif.src_valid & dif.src_enable;
        m_done = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (!found && req[(m_rr + k) % N]) begin
                    m_gid = (m_rr + k) % N;
                    found = 1'b1;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (e_wr) begin
            tot_wr++;
            void'(q[m_gid].pop_front());
            if (e_last) begin
                m_done = 1'b1;
                m_rr   = m_gid;
                m_busy = 1'b0;
                tset   = !dif.src_last[m_gid];
            end else begin
                m_cnt++;
            end
        end
        if (tset) m_trunc = 1'b1;
        else if (dif.trunc_clr) m_trunc = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_busy",       64'(dif.busy),       64'd0);
        chk("rst_grant_id",   64'(dif.grant_id),   64'd0);
        chk("rst_pkt_done",   64'(dif.pkt_done),   64'd0);
        chk("rst_trunc_err",  64'(dif.trunc_err),  64'd0);
        chk("rst_src_ready",  64'(dif.src_ready),  64'd0);
        chk("rst_fifo_wr_en", 64'(dif.fifo_wr_en), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (pending() > 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(pending()), 64'd0);
    endtask

    task automatic run_until_beats(input int base, input int want, input int limit);
        int n;
        n = 0;
        while ((tot_wr - base) < want && n < limit) begin
            tick();
            n++;
        end
        chk("beat_progress", 64'(tot_wr - base), 64'(want));
    endtask

    initial begin
        int w0, w1;
        logic [DW-1:0] rb;
        model_reset();
        drive();

        // Single 3-beat packet from source 0.
        do_reset();
        obs_pkts.delete();
        w0 = tot_wr;
        add_pkt(0, 3, 32'hA0, 1'b1);
        repeat (6) tick();
        chk("t1_beats", 64'(tot_wr - w0), 64'd3);
        chk("t1_pkts",  64'(obs_pkts.size()), 64'd1);
        if (obs_pkts.size() > 0) chk("t1_gid", 64'(obs_pkts[0]), 64'd0);

        // All sources busy with 2-beat packets: strict rotation.
        do_reset();
        obs_pkts.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++)
                add_pkt(s, 2, DW'(32'h100 * (s + 1) + 32'h10 * r), 1'b1);
        wait_idle(100);
        chk("t2_pkts", 64'(obs_pkts.size()), 64'd8);
        for (int i = 0; i < 8 && i < obs_pkts.size(); i++)
            chk("t2_order", 64'(obs_pkts[i]), 64'(i % N));

        // Five-cycle FIFO stall mid-packet.
        w0 = tot_wr;
        add_pkt(0, 4, 32'hC0, 1'b1);
        run_until_beats(w0, 2, 20);
        force_full = 1'b1;
        w1 = tot_wr;
        repeat (5) tick();
        chk("t3_stall_wr", 64'(tot_wr - w1), 64'd0);
        force_full = 1'b0;
        wait_idle(40);
        chk("t3_total", 64'(tot_wr - w0), 64'd4);

        // Six-beat packet truncated at MAX_BEATS, remainder sent as new packet.
        obs_pkts.delete();
        add_pkt(2, 6, 32'hD0, 1'b1);
        wait_idle(40);
        chk("t4_trunc_set", 64'(dif.trunc_err), 64'd1);
        chk("t4_pkts", 64'(obs_pkts.size()), 64'd2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("t4_trunc_clr", 64'(dif.trunc_err), 64'd0);

        // Enable mask; dropping an enable mid-packet does not cut the packet.
        do_reset();
        obs_pkts.delete();
        enable = 4'b1011;
        add_pkt(1, 3, 32'hE0, 1'b1);
        add_pkt(2, 2, 32'hE8, 1'b1);
        add_pkt(3, 2, 32'hF0, 1'b1);
        w0 = tot_wr;
        run_until_beats(w0, 1, 20);
        enable = 4'b1001;
        repeat (15) tick();
        chk("t5_pkts", 64'(obs_pkts.size()), 64'd2);
        if (obs_pkts.size() >= 2) begin
            chk("t5_first",  64'(obs_pkts[0]), 64'd1);
            chk("t5_second", 64'(obs_pkts[1]), 64'd3);
        end
        chk("t5_src2_left", 64'(q[2].size()), 64'd2);
        enable = '1;
        wait_idle(40);

        // Reset during the second beat; source 0 must win afterwards.
        add_pkt(1, 3, 32'hB0, 1'b1);
        w0 = tot_wr;
        run_until_beats(w0, 1, 20);
        add_pkt(0, 2, 32'hB8, 1'b1);
        do_reset();
        obs_pkts.delete();
        wait_idle(40);
        chk("t6_pkts", 64'(obs_pkts.size()), 64'd2);
        if (obs_pkts.size() >= 2) begin
            chk("t6_first",  64'(obs_pkts[0]), 64'd0);
            chk("t6_second", 64'(obs_pkts[1]), 64'd1);
        end

        // Randomized traffic, stalls, masks and clears.
        vld_pct  = 70;
        full_pct = 25;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) begin
                int s;
                s  = int'($urandom_range(N - 1));
                rb = $urandom;
                if (q[s].size() < 8) add_pkt(s, int'($urandom_range(6, 1)), rb, 1'b1);
            end
            if ((i % 50) == 0) enable = N'($urandom);
            clr_req = ($urandom_range(31) == 0);
            tick();
        end
        clr_req  = 1'b0;
        vld_pct  = 100;
        full_pct = 0;
        enable   = '1;
        wait_idle(400);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
